// File: rtl/exmem_pkg.sv
// Shared definitions for the multi-port external memory (exmem_arb).
// Default geometry, derived widths and a one-hot to index helper.
package exmem_pkg;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_ADDR_BITS = 16;
  localparam int DEF_DEPTH     = 1024;
  localparam int DEF_NPORTS    = 2;

  // Upper bound on requesters; the one-hot helper is sized for it.
  localparam int MAX_PORTS = 8;

  localparam int BYTES    = DEF_WIDTH / 8;
  localparam int PTR_BITS = (DEF_NPORTS > 1) ? $clog2(DEF_NPORTS) : 1;

  // Convert a one-hot (or all-zero) vector to the index of its set bit.
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_PORTS-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/exmem_arb_if.sv
// Requester-side bus of exmem_arb: flat per-port request vectors plus
// the shared grant / read-return signals. The be vector only exists when
// EXMEM_BYTE_EN is defined.
interface exmem_arb_if
  import exmem_pkg::*;
#(
  parameter int NPORTS    = DEF_NPORTS,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ADDR_BITS = DEF_ADDR_BITS
);

  localparam int NBYTES = WIDTH / 8;

  logic                        en;
  logic [NPORTS-1:0]           req;
  logic [NPORTS-1:0]           we;
  logic [NPORTS*ADDR_BITS-1:0] adr;
  logic [NPORTS*WIDTH-1:0]     wdata;
`ifdef EXMEM_BYTE_EN
  logic [NPORTS*NBYTES-1:0]    be;
`endif
  logic [NPORTS-1:0]           gnt;
  logic [NPORTS-1:0]           rvalid;
  logic [WIDTH-1:0]            rdata;

`ifdef EXMEM_BYTE_EN
  modport master (output en, req, we, adr, wdata, be, input gnt, rvalid, rdata);
  modport slave  (input  en, req, we, adr, wdata, be, output gnt, rvalid, rdata);
`else
  modport master (output en, req, we, adr, wdata, input gnt, rvalid, rdata);
  modport slave  (input  en, req, we, adr, wdata, output gnt, rvalid, rdata);
`endif

endinterface

// File: rtl/exmem_arb_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant, scanning from the port
// after the last winner. The pointer only moves when a grant is issued.
module rr_arb
  import exmem_pkg::*;
#(
  parameter int NPORTS = DEF_NPORTS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic [NPORTS-1:0] i_req,
  output logic [NPORTS-1:0] o_gnt
);

  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  logic [PW-1:0]     r_ptr;
  logic [NPORTS-1:0] w_gnt;
  logic [2:0]        w_gidx;

  // Grant the first requester found scanning ptr+1 .. ptr+NPORTS (mod NPORTS).
  always_comb begin
    logic        found;
    logic [PW:0] sum;
    // NOTE: every comb output gets a default first so no path can infer a latch.
    w_gnt = '0;
    found = 1'b0;
    sum   = '0;
    if (i_en) begin
      for (int k = 1; k <= NPORTS; k++) begin
        sum = {1'b0, r_ptr} + (PW+1)'(k);
        if (sum >= (PW+1)'(NPORTS)) sum = sum - (PW+1)'(NPORTS);
        if (!found && i_req[sum[PW-1:0]]) begin
          w_gnt[sum[PW-1:0]] = 1'b1;
          found              = 1'b1;
        end
      end
    end
  end

  assign w_gidx = onehot_to_idx(MAX_PORTS'(w_gnt));
  assign o_gnt  = w_gnt;

  // Remember the last winner; reset points at the top port so port 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= PW'(NPORTS - 1);
    end else if (|w_gnt) begin
      // NOTE: sequential state always uses non-blocking assignment.
      r_ptr <= PW'(w_gidx);
    end
  end

endmodule

// File: rtl/exmem_arb.sv
// exmem_arb: single-bank synchronous RAM shared by NPORTS requesters.
// One round-robin grant per cycle; reads return on a shared registered bus
// one cycle after the grant. Addresses >= DEPTH ignore writes, read as 0.
// Optional feature macro: EXMEM_BYTE_EN (per-byte write enables on bus.be).
module exmem_arb
  import exmem_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int NPORTS    = DEF_NPORTS
) (
  input  logic         clk,
  input  logic         rst_n,
  exmem_arb_if.slave   bus
);

  localparam int PW     = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NBYTES = WIDTH / 8;

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [WIDTH-1:0]     r_rdata;
  logic [NPORTS-1:0]    r_rvalid;

  logic [NPORTS-1:0]    w_gnt;
  logic                 w_any;
  logic [PW-1:0]        w_sel;
  logic [ADDR_BITS-1:0] w_adr;
  logic [WIDTH-1:0]     w_wdata;
  logic                 w_in_range;
  logic [AW-1:0]        w_idx;
  logic                 w_wr;
  logic                 w_rd;

  rr_arb #(.NPORTS(NPORTS)) u_rr_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (bus.en),
    .i_req (bus.req),
    .o_gnt (w_gnt)
  );

  // Unpack the winning port's request from the flat bus vectors.
  assign w_any      = |w_gnt;
  assign w_sel      = PW'(onehot_to_idx(MAX_PORTS'(w_gnt)));
  assign w_adr      = bus.adr[int'(w_sel)*ADDR_BITS +: ADDR_BITS];
  assign w_wdata    = bus.wdata[int'(w_sel)*WIDTH +: WIDTH];
  assign w_in_range = 32'(w_adr) < 32'(DEPTH);
  assign w_idx      = w_adr[AW-1:0];
  assign w_wr       = w_any &  bus.we[w_sel] & w_in_range;
  assign w_rd       = w_any & ~bus.we[w_sel];

`ifdef EXMEM_BYTE_EN
  logic [NBYTES-1:0] w_be;
  assign w_be = bus.be[int'(w_sel)*NBYTES +: NBYTES];

  // Granted write: update only the enabled byte lanes.
  // NOTE: the RAM array has no reset; its contents survive rst_n by design.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
      end
    end
  end
`else
  // Granted write: full-word update.
  // NOTE: the RAM array has no reset; its contents survive rst_n by design.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[w_idx] <= w_wdata;
  end
`endif

  // Read return register: data and one-hot owner, valid only the cycle after a granted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= '0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= '0;
      if (w_rd) begin
        r_rvalid <= w_gnt;
        r_rdata  <= w_in_range ? r_mem[w_idx] : '0;
      end
    end
  end

  assign bus.gnt    = w_gnt;
  assign bus.rvalid = r_rvalid;
  assign bus.rdata  = r_rdata;

endmodule

// File: tb/tb_exmem_arb.sv
// Directed bench for exmem_arb (NPORTS=2, WIDTH=16, DEPTH=1024).
// Inputs change 1ns after the rising edge; outputs are sampled there or at
// the falling edge. Byte-enable checks follow EXMEM_BYTE_EN.
module tb_exmem_arb;

  localparam int NP    = 2;
  localparam int W     = 16;
  localparam int AB    = 16;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  exmem_arb_if #(.NPORTS(NP), .WIDTH(W), .ADDR_BITS(AB)) bus ();

  exmem_arb #(.WIDTH(W), .ADDR_BITS(AB), .DEPTH(DEPTH), .NPORTS(NP)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

`ifdef EXMEM_BYTE_EN
  logic [1:0] cur_be = 2'b11;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    bus.req = '0;
    bus.we  = '0;
  endtask

  task automatic issue(input int p, input logic w, input logic [15:0] a, input logic [15:0] d);
    bus.req               = '0;
    bus.we                = '0;
    bus.req[p]            = 1'b1;
    bus.we[p]             = w;
    bus.adr[p*AB +: AB]   = a;
    bus.wdata[p*W +: W]   = d;
`ifdef EXMEM_BYTE_EN
    bus.be[p*2 +: 2]      = cur_be;
`endif
  endtask

  task automatic do_write(input string tag, input int p, input logic [15:0] a, input logic [15:0] d);
    issue(p, 1'b1, a, d);
    @(negedge clk);
    check({tag, " gnt"}, 32'(bus.gnt), 32'(1 << p));
    next_cycle();
    clear_req();
    check({tag, " rvalid"}, 32'(bus.rvalid), 32'd0);
  endtask

  task automatic do_read(input string tag, input int p, input logic [15:0] a, input logic [15:0] exp);
    issue(p, 1'b0, a, 16'h0000);
    @(negedge clk);
    check({tag, " gnt"}, 32'(bus.gnt), 32'(1 << p));
    next_cycle();
    clear_req();
    check({tag, " rvalid"}, 32'(bus.rvalid), 32'(1 << p));
    check({tag, " rdata"},  32'(bus.rdata),  32'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_g;
    logic [1:0] exp_rv;

    rst_n     = 1'b0;
    bus.en    = 1'b1;
    bus.req   = 2'b11;
    bus.we    = 2'b00;
    bus.adr   = '0;
    bus.wdata = '0;
`ifdef EXMEM_BYTE_EN
    bus.be    = '1;
`endif

    // Reset state with both ports requesting.
    #2;
    check("rst rvalid", 32'(bus.rvalid), 32'd0);
    check("rst rdata",  32'(bus.rdata),  32'd0);
    @(negedge clk);
    check("rst first gnt", 32'(bus.gnt), 32'h1);
    #1 rst_n = 1'b1;
    next_cycle();

    // Fairness: continuous reads on both ports alternate, rvalid trails gnt.
    exp_g  = 2'b10;
    exp_rv = 2'b01;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("rr%0d rvalid", i), 32'(bus.rvalid), 32'(exp_rv));
      @(negedge clk);
      check($sformatf("rr%0d gnt", i), 32'(bus.gnt), 32'(exp_g));
      exp_rv = exp_g;
      exp_g  = ~exp_g;
      next_cycle();
    end
    clear_req();
    next_cycle();
    check("idle rvalid", 32'(bus.rvalid), 32'd0);

    // Read-after-write across ports, then rdata holds while idle.
    do_write("raw wr", 1, 16'h0005, 16'hBEEF);
    do_read ("raw rd", 0, 16'h0005, 16'hBEEF);
    next_cycle();
    check("hold rvalid", 32'(bus.rvalid), 32'd0);
    check("hold rdata",  32'(bus.rdata),  32'hBEEF);

    // Address boundary: 0x400 is out of range and must not alias onto 0x000.
    do_write("bnd wr0",   0, 16'h0000, 16'h1111);
    do_write("bnd wr3ff", 0, 16'h03FF, 16'h7777);
    do_write("bnd wr400", 1, 16'h0400, 16'h1234);
    do_read ("bnd rd400", 1, 16'h0400, 16'h0000);
    do_read ("bnd rd3ff", 0, 16'h03FF, 16'h7777);
    do_read ("bnd rd0",   0, 16'h0000, 16'h1111);
    do_read ("bnd rdfff", 1, 16'hFFFF, 16'h0000);

    // Reset pulsed right after a granted read drops its rvalid.
    issue(0, 1'b0, 16'h0005, 16'h0000);
    @(negedge clk);
    check("mid gnt", 32'(bus.gnt), 32'h1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    clear_req();
    #1;
    check("mid rst rvalid", 32'(bus.rvalid), 32'd0);
    check("mid rst rdata",  32'(bus.rdata),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    check("post rst rvalid", 32'(bus.rvalid), 32'd0);

    // Pointer restored by reset; en=0 blocks grants and freezes the pointer.
    bus.req = 2'b11;
    #1;
    check("ptr rst gnt", 32'(bus.gnt), 32'h1);
    bus.en = 1'b0;
    #1;
    check("en0 gnt", 32'(bus.gnt), 32'd0);
    next_cycle();
    next_cycle();
    check("en0 rvalid", 32'(bus.rvalid), 32'd0);
    check("en0 gnt hold", 32'(bus.gnt), 32'd0);
    bus.en = 1'b1;
    #1;
    check("en1 gnt", 32'(bus.gnt), 32'h1);
    clear_req();
    do_read("ram kept", 0, 16'h0005, 16'hBEEF);

    // Partial write: only the low byte lane is enabled in the byte-enable build.
    do_write("be wr full", 0, 16'h0010, 16'hAAAA);
`ifdef EXMEM_BYTE_EN
    cur_be = 2'b01;
    do_write("be wr lo", 0, 16'h0010, 16'h5555);
    cur_be = 2'b00;
    do_write("be wr none", 0, 16'h0010, 16'h0000);
    cur_be = 2'b11;
    do_read("be rd", 0, 16'h0010, 16'hAA55);
`else
    do_write("be wr lo", 0, 16'h0010, 16'h5555);
    do_read("be rd", 0, 16'h0010, 16'h5555);
`endif

    next_cycle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
